// File: rtl/fifo_pkg.sv
// Shared async-FIFO pointer types and Gray/binary helpers.
// Used by both the read-side and write-side pointer controllers.
package fifo_pkg;

  localparam int ADDRSIZE_DEF = 4;

  typedef logic [ADDRSIZE_DEF:0] ptr_t;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/rptr_empty_wclk_if.sv
// Read-side bundle of the return-channel async FIFO.
// Level ports exist only when RPTR_EMPTY_LEVEL_EN is defined.
interface rptr_empty_wclk_if #(
  parameter int ADDRSIZE = 4
);
  logic                rinc;
  logic [ADDRSIZE:0]   rq_wptr;
  logic [ADDRSIZE-1:0] raddr;
  logic [ADDRSIZE:0]   rptr;
  logic                rempty;
`ifdef RPTR_EMPTY_LEVEL_EN
  logic [ADDRSIZE:0]   rcount;
  logic                ralmost_empty;
`endif

`ifdef RPTR_EMPTY_LEVEL_EN
  modport master (
    output rinc, rq_wptr,
    input  raddr, rptr, rempty,
    input  rcount, ralmost_empty
  );
  modport slave (
    input  rinc, rq_wptr,
    output raddr, rptr, rempty,
    output rcount, ralmost_empty
  );
`else
  modport master (
    output rinc, rq_wptr,
    input  raddr, rptr, rempty
  );
  modport slave (
    input  rinc, rq_wptr,
    output raddr, rptr, rempty
  );
`endif

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer, parameterized width, async active-low reset.
// Shared with the remote write side.
module sync_2ff #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] q1;

  // first stage may go metastable; only the second stage is consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1 <= '0;
      q  <= '0;
    end else begin
      q1 <= d;
      q  <= q1;
    end
  end

endmodule

// File: rtl/rptr_empty_wclk.sv
// Read pointer / empty flag controller, reader in wclk domain.
// Optional occupancy + almost-empty under RPTR_EMPTY_LEVEL_EN.
module rptr_empty_wclk
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE = ADDRSIZE_DEF,
  parameter int AE_LEVEL = 1
) (
  input  logic           wclk,
  input  logic           wrst_n,
  rptr_empty_wclk_if.slave bus
);
  logic [ADDRSIZE:0] wq2;
  logic [ADDRSIZE:0] rbin;
  logic [ADDRSIZE:0] rbinnext;
  logic [ADDRSIZE:0] rgraynext;
  logic [ADDRSIZE:0] rptr_q;
  logic              rempty_q;
  logic              accept;

  sync_2ff #(.WIDTH(ADDRSIZE+1)) u_sync (
    .clk   (wclk),
    .rst_n (wrst_n),
    .d     (bus.rq_wptr),
    .q     (wq2)
  );

  // next pointer: advance only on a read while not empty
  always_comb begin
    accept    = bus.rinc & ~rempty_q;
    rbinnext  = rbin + {{ADDRSIZE{1'b0}}, accept};
    rgraynext = (rbinnext >> 1) ^ rbinnext;
  end

  // pointers and empty flag; empty sees the local read immediately
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      rbin     <= '0;
      rptr_q   <= '0;
      rempty_q <= 1'b1;
    end else begin
      rbin     <= rbinnext;
      rptr_q   <= rgraynext;
      rempty_q <= (rgraynext == wq2);
    end
  end

  assign bus.raddr  = rbin[ADDRSIZE-1:0];
  assign bus.rptr   = rptr_q;
  assign bus.rempty = rempty_q;

`ifdef RPTR_EMPTY_LEVEL_EN
  localparam logic [ADDRSIZE:0] AE_LIM = AE_LEVEL[ADDRSIZE:0];

  logic [31:0]       wq2_b32;
  logic [ADDRSIZE:0] wq2_bin;
  logic [ADDRSIZE:0] diff;
  logic [ADDRSIZE:0] rcount_q;
  logic              rae_q;

  // occupancy from synchronized write ptr vs post-read local ptr
  always_comb begin
    wq2_b32 = gray2bin(32'(wq2));
    wq2_bin = wq2_b32[ADDRSIZE:0];
    diff    = wq2_bin - rbinnext;
  end

  // registered level outputs, same edge as rempty
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      rcount_q <= '0;
      rae_q    <= 1'b1;
    end else begin
      rcount_q <= diff;
      rae_q    <= (diff <= AE_LIM);
    end
  end

  assign bus.rcount        = rcount_q;
  assign bus.ralmost_empty = rae_q;
`endif

endmodule

// File: tb/tb_rptr_empty_wclk.sv
// Directed bench for rptr_empty_wclk (ADDRSIZE=4, AE_LEVEL=1).
// Level checks are active when RPTR_EMPTY_LEVEL_EN is defined.
module tb_rptr_empty_wclk;

  localparam int AS = 4;

  logic wclk = 1'b0;
  logic wrst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  rptr_empty_wclk_if #(.ADDRSIZE(AS)) bus ();

  rptr_empty_wclk #(.ADDRSIZE(AS), .AE_LEVEL(1)) dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .bus    (bus)
  );

  always #5 wclk = ~wclk;

  typedef struct {
    logic       rinc;
    logic [4:0] wptr;
    logic       e_empty;
    logic [3:0] e_addr;
    logic [4:0] e_ptr;
    logic [4:0] e_cnt;
    logic       e_ae;
  } vec_t;

  vec_t vecs[11];

  function automatic logic [4:0] g(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_outs(input string nm, input logic e_empty,
                          input logic [3:0] e_addr, input logic [4:0] e_ptr,
                          input logic [4:0] e_cnt, input logic e_ae);
    chk({nm, ".rempty"}, 32'(bus.rempty), 32'(e_empty));
    chk({nm, ".raddr"}, 32'(bus.raddr), 32'(e_addr));
    chk({nm, ".rptr"}, 32'(bus.rptr), 32'(e_ptr));
`ifdef RPTR_EMPTY_LEVEL_EN
    chk({nm, ".rcount"}, 32'(bus.rcount), 32'(e_cnt));
    chk({nm, ".ralmost_empty"}, 32'(bus.ralmost_empty), 32'(e_ae));
`else
    if (e_cnt > 5'd16 && e_ae) chk({nm, ".cnt"}, 32'(e_cnt), 32'(0));
`endif
  endtask

  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  task automatic do_reset();
    wrst_n = 1'b0;
    bus.rinc = 1'b0;
    bus.rq_wptr = '0;
    step();
    wrst_n = 1'b1;
  endtask

  logic [4:0] rb;
  logic [4:0] wb;
  logic [4:0] prev;

  initial begin
    vecs[0]  = '{1'b0, 5'd1, 1'b1, 4'd0, 5'd0, 5'd0, 1'b1};
    vecs[1]  = '{1'b0, 5'd1, 1'b1, 4'd0, 5'd0, 5'd0, 1'b1};
    vecs[2]  = '{1'b0, 5'd1, 1'b0, 4'd0, 5'd0, 5'd1, 1'b1};
    vecs[3]  = '{1'b1, 5'd1, 1'b1, 4'd1, 5'd1, 5'd0, 1'b1};
    vecs[4]  = '{1'b1, 5'd1, 1'b1, 4'd1, 5'd1, 5'd0, 1'b1};
    vecs[5]  = '{1'b0, 5'd2, 1'b1, 4'd1, 5'd1, 5'd0, 1'b1};
    vecs[6]  = '{1'b0, 5'd2, 1'b1, 4'd1, 5'd1, 5'd0, 1'b1};
    vecs[7]  = '{1'b0, 5'd2, 1'b0, 4'd1, 5'd1, 5'd2, 1'b0};
    vecs[8]  = '{1'b1, 5'd2, 1'b0, 4'd2, 5'd3, 5'd1, 1'b1};
    vecs[9]  = '{1'b1, 5'd2, 1'b1, 4'd3, 5'd2, 5'd0, 1'b1};
    vecs[10] = '{1'b1, 5'd6, 1'b1, 4'd3, 5'd2, 5'd0, 1'b1};

    bus.rinc = 1'b0;
    bus.rq_wptr = '0;

    // reset held while the remote pointer toggles
    for (int i = 0; i < 6; i++) begin
      bus.rq_wptr = 5'($urandom);
      bus.rinc = 1'($urandom);
      step();
      chk_outs("rst_hold", 1'b1, 4'd0, 5'd0, 5'd0, 1'b1);
    end
    bus.rq_wptr = '0;
    bus.rinc = 1'b0;
    #2 wrst_n = 1'b1;

    // table: single write latency, reads, empty-read ignore
    for (int i = 0; i < 11; i++) begin
      bus.rinc = vecs[i].rinc;
      bus.rq_wptr = vecs[i].wptr;
      step();
      chk_outs($sformatf("vec%0d", i), vecs[i].e_empty, vecs[i].e_addr,
               vecs[i].e_ptr, vecs[i].e_cnt, vecs[i].e_ae);
    end

    // drain a full FIFO
    do_reset();
    bus.rq_wptr = g(5'd16);
    step();
    step();
    step();
    chk_outs("full", 1'b0, 4'd0, 5'd0, 5'd16, 1'b0);
    bus.rinc = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i < 16) chk($sformatf("drain_raddr%0d", i), 32'(bus.raddr), i);
      step();
      rb = (i < 16) ? 5'(i + 1) : 5'd16;
      chk($sformatf("drain_empty%0d", i), 32'(bus.rempty),
          32'(i >= 15));
      chk($sformatf("drain_rptr%0d", i), 32'(bus.rptr), 32'(g(rb)));
    end
    chk_outs("drained", 1'b1, 4'd0, 5'd24, 5'd0, 1'b1);

    // empty reads leave everything untouched
    for (int i = 0; i < 5; i++) begin
      step();
      chk_outs("empty_rd", 1'b1, 4'd0, 5'd24, 5'd0, 1'b1);
    end
    bus.rinc = 1'b0;

    // 40 write/read pairs across the 31->0 wrap
    wb = 5'd16;
    rb = 5'd16;
    for (int i = 0; i < 40; i++) begin
      wb = wb + 5'd1;
      bus.rq_wptr = g(wb);
      step();
      step();
      step();
      chk($sformatf("wrap_ne%0d", i), 32'(bus.rempty), 0);
      prev = bus.rptr;
      bus.rinc = 1'b1;
      step();
      bus.rinc = 1'b0;
      rb = rb + 5'd1;
      chk($sformatf("wrap_ptr%0d", i), 32'(bus.rptr), 32'(g(rb)));
      chk($sformatf("wrap_1bit%0d", i), 32'($countones(prev ^ bus.rptr)), 1);
      chk($sformatf("wrap_e%0d", i), 32'(bus.rempty), 1);
    end

    // mid-operation async reset with 7 words queued
    do_reset();
    bus.rq_wptr = g(5'd7);
    step();
    step();
    step();
    chk_outs("pre_rst", 1'b0, 4'd0, 5'd0, 5'd7, 1'b0);
    bus.rinc = 1'b1;
    step();
    bus.rinc = 1'b0;
    chk_outs("pre_rst_rd", 1'b0, 4'd1, 5'd1, 5'd6, 1'b0);
    #2 wrst_n = 1'b0;
    #1;
    chk_outs("async_rst", 1'b1, 4'd0, 5'd0, 5'd0, 1'b1);
    step();
    chk_outs("rst_edge", 1'b1, 4'd0, 5'd0, 5'd0, 1'b1);
    bus.rq_wptr = g(5'd3);
    #2 wrst_n = 1'b1;
    step();
    chk_outs("rel1", 1'b1, 4'd0, 5'd0, 5'd0, 1'b1);
    step();
    chk_outs("rel2", 1'b1, 4'd0, 5'd0, 5'd0, 1'b1);
    step();
    chk_outs("rel3", 1'b0, 4'd0, 5'd0, 5'd3, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rptr_empty_wclk.md
# rptr_empty_wclk

Read-pointer and empty-flag controller for the return-channel asynchronous FIFO. The reader of this FIFO lives in the wclk domain, and its writer lives in the remote domain. The block synchronizes the remote Gray write pointer into wclk and advances a binary/Gray read pointer on accepted reads. It generates a registered empty flag and, optionally, an occupancy count with an almost-empty flag. It pairs with the remote-side write-pointer/full controller and shares the same dual-port memory.

## Interface
- ADDRSIZE, 4, memory address width; depth = 2^ADDRSIZE, pointers ADDRSIZE+1 bits
- AE_LEVEL, 1, almost-empty threshold in words (only with level feature); legal 0..2^ADDRSIZE-1

- wclk  in  1  clock
- wrst_n  in  1  reset, asynchronous, active-low
- rinc  in  1  read request; accepted only when rempty=0
- rq_wptr  in  ADDRSIZE+1  remote Gray write pointer, asynchronous to wclk
- raddr  out  ADDRSIZE  memory read address = rbin[ADDRSIZE-1:0]
- rptr  out  ADDRSIZE+1  registered Gray read pointer, sent to the remote domain's synchronizer
- rempty  out  1  registered empty flag
- rcount  out  ADDRSIZE+1  registered occupancy (level feature only)
- ralmost_empty  out  1  registered, rcount ≤ AE_LEVEL (level feature only)

## Operation
- Synchronizer: two flops, wq1 then wq2, sample rq_wptr. Only wq2 feeds logic.
- Read accept: rinc & ~rempty. rbinnext = rbin + accept. rgraynext = (rbinnext>>1) ^ rbinnext.
- Pointer register: {rbin, rptr} <= {rbinnext, rgraynext} every edge. Pointers wrap modulo 2^(ADDRSIZE+1), with no special case.
- Empty: rempty <= (rgraynext == wq2). Equality is on the full ADDRSIZE+1 bits.
- rinc while rempty=1 is ignored: pointers hold and nothing errors. raddr still shows the current location.
- Level feature:
  - wq2_bin = Gray-to-binary(wq2).
  - rcount <= wq2_bin - rbinnext, modulo 2^(ADDRSIZE+1).
  - ralmost_empty <= (wq2_bin - rbinnext) ≤ AE_LEVEL.
- Invariants:
  - rempty=1 ⇔ rcount=0.
  - rcount ≤ 2^ADDRSIZE.
  - rptr changes by at most one bit per edge.
- Flags are pessimistic: a remote write is seen late, and a local read is seen immediately.
- Reset values:
  - wq1=wq2=0, rbin=0, rptr=0, raddr=0.
  - rempty=1, rcount=0, ralmost_empty=1.

## Timing
- Read to empty: an accepted read on edge N updates rptr/raddr at N. If that read consumed the last word, rempty=1 also at N, with zero added latency.
- Remote write to visible: rq_wptr is stable before edge N. It lands in wq1 at N, wq2 at N+1, and rempty/rcount update at N+2.
- raddr is valid in the cycle rinc is presented. The memory read is outside this block.
- Simultaneous remote write and local read in the same cycle: both take effect independently. rcount reflects the read immediately and the write two edges later.
- Reset mid-operation: all registers clear asynchronously on wrst_n fall, and outputs take their reset values at once. The first accept is possible on the first edge after release once wq2 ≠ 0.
- rempty is glitch-free and registered. No combinational path exists from rq_wptr to any output.

## Configuration
- RPTR_EMPTY_LEVEL_EN:
  - Defined: the Gray-to-binary converter and the rcount/ralmost_empty registers and ports are present.
  - Undefined: those ports and registers are absent, AE_LEVEL is unused, and behaviour of rempty/rptr/raddr is identical.

## Structure
- Shared package fifo_pkg holds:
  - default ADDRSIZE constant
  - pointer typedef (logic [ADDRSIZE:0])
  - gray2bin and bin2gray functions
- One sub-module: sync_2ff, a parameterized-width two-flop synchronizer with async active-low reset, reused by the remote write side.

## Test plan
- Reset: hold wrst_n=0, toggle rq_wptr randomly → rempty=1, rptr=0, raddr=0, rcount=0, ralmost_empty=1 throughout.
- Single remote write: rq_wptr 0→1 before edge N → rempty falls at N+2; rcount=1 and ralmost_empty=1 at N+2 (AE_LEVEL=1).
- Drain: rq_wptr=Gray(16) (full, ADDRSIZE=4), rinc=1 for 20 cycles → exactly 16 accepts, raddr 0..15, rempty=1 on the 16th accept edge, pointers frozen after.
- Empty read: rempty=1, rinc=1 for 5 cycles → rbin, rptr, raddr unchanged.
- Wrap-around: 40 write/read pairs → rptr walks the Gray sequence through 31→0 with one-bit changes, and rempty is correct at each wrap.
- Mid-operation reset: rcount=7, assert wrst_n for 1 cycle → all outputs at reset values immediately. rq_wptr=Gray(3) after release → rempty=0 and rcount=3 two edges after release.
